mux16_scan_ctrl: RTL
====================

Name: mux16_scan_ctrl

Overview:
- Sequencer that drives the 4-bit select of the 16:1 mux tree and reassembles its 1-bit output into a 16-bit word.
- Sits directly downstream of, and in closed loop with, the mux: it produces S[3:0] and consumes out.
- Effectively a mux-based parallel capture. One start request gives one scan of channels 0..15, then one registered word and a one-cycle valid pulse.

Parameters:
- SETTLE_CYCLES, 0: idle cycles after each select change before sampling mux_out (covers mux propagation and off-chip settling); range 0..15.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  scan request; accepted only when busy=0
- abort  input  1  synchronous scan cancel
- mux_out  input  1  output of the 16:1 mux
- sel  output  4  registered select to the mux S[3:0]
- busy  output  1  high from the accept edge until scan completion or abort
- data_out  output  16  last completed scan; bit i = channel i
- valid  output  1  one-cycle pulse when data_out updates

Behaviour:
- Reset (async, rst_n=0): state IDLE, sel=0, settle counter=0, shadow=0, data_out=16'h0000, valid=0, busy=0.
- States:
  - IDLE: sel=0, busy=0.
  - SETTLE: count down SETTLE_CYCLES.
  - SAMPLE: capture one channel.
- IDLE, start=1, abort=0: at the edge, busy<=1, sel<=0. Next state is SETTLE with counter=SETTLE_CYCLES-1, or SAMPLE if SETTLE_CYCLES=0.
- SETTLE: decrement each cycle; on reaching 0, go to SAMPLE.
- SAMPLE, sel<15:
  - shadow[sel]<=mux_out.
  - sel<=sel+1.
  - Go to SETTLE, or stay in SAMPLE if SETTLE_CYCLES=0.
- SAMPLE, sel=15:
  - data_out<={mux_out, shadow[14:0]}.
  - valid<=1 for exactly one cycle.
  - busy<=0, sel<=0, go to IDLE.
- Latency: valid rises 16*(SETTLE_CYCLES+1) cycles after the accept edge. With SETTLE_CYCLES=0, the accept edge is E0, samples occur at E1..E16, and valid is high in the cycle after E16.
- sel changes only at a state-transition edge and never mid-settle. It is held stable for SETTLE_CYCLES+1 cycles per channel.
- start while busy=1: ignored, with no queuing.
- start and valid in the same cycle: in base build, start is accepted because the state is already IDLE. The next scan begins, and the valid pulse is unaffected.
- abort=1 in any non-IDLE state: at the edge, go to IDLE, sel<=0, busy<=0. data_out keeps its last completed value and valid is not asserted. Shadow is don't-care.
- abort and start both high in IDLE: abort wins and start is ignored.
- abort in the same cycle as the final SAMPLE (sel=15): abort wins, with no valid and no data_out update.
- Reset mid-scan: immediate return to reset values, and data_out is cleared.
- Counter widths: sel is 4-bit and never wraps past 15 within a scan. The settle counter is 4-bit.

Optional Feature:
- Macro: MUX16_SCAN_CONT_EN.
- Defined:
  - Adds input port cont (1 bit).
  - If cont=1 at the completing SAMPLE edge, valid still pulses and data_out updates. busy stays 1, sel<=0, and the next scan starts immediately in SETTLE/SAMPLE.
  - Back-to-back valid period is 16*(SETTLE_CYCLES+1) cycles.
  - abort still terminates the scan.
- Undefined: no cont port. Every scan needs a new start, and behaviour is exactly as above.

Decomposition:
- Shared package mux16_pkg holds:
  - NUM_CH=16 and CH_W=4.
  - The state enum type scan_state_t with IDLE, SETTLE, SAMPLE.
  - The data word width constant.
- One natural sub-module, mux16_settle_cnt: a loadable down-counter with a zero flag, parameterised by SETTLE_CYCLES.
- The mux itself stays external. The bench instantiates the existing 16:1 mux between sel and mux_out.

Test Plan:
- SETTLE_CYCLES=0, mux A=16'hA5C3, pulse start → sel steps 0..15 on consecutive cycles; valid high 16 cycles after the accept edge; data_out=16'hA5C3; busy low the same cycle valid is high.
- SETTLE_CYCLES=2, A=16'h8001 → each sel value held 3 cycles; valid after 48 cycles; data_out=16'h8001.
- A=16'hFFFF, raise abort while sel=5 → next cycle busy=0, sel=0, no valid pulse, data_out keeps prior value 16'h8001.
- Scan in progress with A=16'h1234, pulse start at sel=7 → ignored; a single valid pulse with data_out=16'h1234; exactly 16 samples taken.
- Drop rst_n at sel=10 → data_out=0, busy=0, sel=0 asynchronously. Release rst_n and start with A=16'h00F0 → data_out=16'h00F0.
- MUX16_SCAN_CONT_EN, cont=1, SETTLE_CYCLES=0, change A from 16'h0F0F to 16'hF0F0 mid-scan 2 → valid pulses every 16 cycles with busy held high. Scan 1 gives 16'h0F0F. Scan 2 gives mixed bits per the channels sampled before and after the change.

Source files
------------

// File: rtl/mux16_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux16_pkg : shared constants and state type for the 16-channel mux scanner
// Revision  : 1.0
// ---------------------------------------------------------------------------
package mux16_pkg;

  localparam int NUM_CH = 16;
  localparam int CH_W   = 4;
  localparam int DATA_W = NUM_CH;
  localparam int CNT_W  = 4;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/mux16_settle_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux16_settle_cnt : loadable down-counter with zero flag, loads SETTLE_CYCLES-1
// Revision         : 1.0
// ---------------------------------------------------------------------------
module mux16_settle_cnt
  import mux16_pkg::*;
#(
  parameter int SETTLE_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic zero
);

  localparam logic [CNT_W-1:0] LOAD_VAL =
    (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Free-runs down to zero and parks there until the next load.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/mux16_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux16_scan_ctrl : walks the 16:1 mux select and assembles a 16-bit capture.
// Optional continuous scanning via macro MUX16_SCAN_CONT_EN (adds port cont).
// Revision        : 1.0
// ---------------------------------------------------------------------------
module mux16_scan_ctrl
  import mux16_pkg::*;
#(
  parameter int SETTLE_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
`ifdef MUX16_SCAN_CONT_EN
  input  logic              cont,
`endif
  input  logic              mux_out,
  output logic [CH_W-1:0]   sel,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              valid
);

  localparam bit NO_SETTLE = (SETTLE_CYCLES == 0);

  scan_state_t       state_q, state_d;
  logic [CH_W-1:0]   sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-2:0] shadow_q, shadow_d;
  logic              cnt_load;
  logic              cnt_zero;
  logic              cont_en;

`ifdef MUX16_SCAN_CONT_EN
  assign cont_en = cont;
`else
  assign cont_en = 1'b0;
`endif

  mux16_settle_cnt #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (cnt_load),
    .zero (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    shadow_d = shadow_q;
    cnt_load = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d   = 1'b1;
          sel_d    = '0;
          state_d  = NO_SETTLE ? SAMPLE : SETTLE;
          cnt_load = !NO_SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (sel_q != LAST_CH) begin
          shadow_d[sel_q] = mux_out;
          sel_d           = sel_q + CH_W'(1);
          state_d         = NO_SETTLE ? SAMPLE : SETTLE;
          cnt_load        = !NO_SETTLE;
        end else begin
          data_d  = {mux_out, shadow_q};
          valid_d = 1'b1;
          sel_d   = '0;
          if (cont_en) begin
            state_d  = NO_SETTLE ? SAMPLE : SETTLE;
            cnt_load = !NO_SETTLE;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    // Abort overrides everything: in IDLE it just blocks a start, mid-scan it
    // discards the partial capture without touching data_out.
    if (abort) begin
      state_d  = IDLE;
      sel_d    = '0;
      busy_d   = 1'b0;
      valid_d  = 1'b0;
      data_d   = data_q;
      cnt_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      shadow_q <= shadow_d;
    end
  end

  assign sel      = sel_q;
  assign busy     = busy_q;
  assign valid    = valid_q;
  assign data_out = data_q;

endmodule
`default_nettype wire
